// File: rtl/spi_flash_responder.sv
// spi_flash_responder
//   SPI mode-0 flash target. It decodes READ (0x03) and READ-ID (0x9F) from
//   the SPI pins and returns flash bytes on MISO. Flash words come from a
//   backing memory through a req/ack word-read handshake. All SPI pins are
//   oversampled on the system clock.
//
// Ports
//   clock, reset     system clock, asynchronous active-low reset
//   spi_sck/ss/mosi  SPI pins from the master (mode 0, SS active low)
//   spi_miso         SPI data back to the master (1 when not driving data)
//   mem_req/addr     word read request (held until mem_ack), word address
//   mem_ack/rdata    one-cycle acknowledge with the little-endian word
//   busy             SS is seen low after synchronisation
//   underrun         sticky: a data bit was needed before its word arrived
module spi_flash_responder #(
  parameter logic [23:0] jedec_id  = 24'hEF4017,
  parameter int          addr_bits = 24
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 spi_sck,
  input  logic                 spi_ss,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic                 mem_req,
  output logic [addr_bits-3:0] mem_addr,
  input  logic                 mem_ack,
  input  logic [31:0]          mem_rdata,
  output logic                 busy,
  output logic                 underrun
);

  localparam int          WA_W      = addr_bits - 2;
  localparam logic [5:0]  ADDR_LAST = 6'(addr_bits - 1);
  // ID bits followed by ones, so the index below never leaves the vector.
  localparam logic [31:0] ID_EXT    = {jedec_id, 8'hFF};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_READ,
    S_ID,
    S_IGNORE
  } state_t;

  logic sck_s1_q, sck_s2_q, sck_prev_q;
  logic ss_s1_q, ss_s2_q, ss_prev_q;
  logic mosi_s1_q, mosi_s2_q;

  state_t            state_q, state_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic [1:0]        byte_ptr_q, byte_ptr_d;
  logic              miso_q, miso_d;
  logic              mem_req_q, mem_req_d;
  logic [WA_W-1:0]   mem_addr_q, mem_addr_d;
  logic [WA_W-1:0]   nxt_waddr_q, nxt_waddr_d;
  logic              cur_vld_q, cur_vld_d;
  logic              pf_vld_q, pf_vld_d;
  logic              pf_pend_q, pf_pend_d;
  logic              underrun_q, underrun_d;

  logic [addr_bits-2:0] shift_q, shift_d;
  logic [31:0]          cur_word_q, cur_word_d;
  logic [31:0]          pf_word_q, pf_word_d;

  logic                 sck_rise, sck_fall, ss_fall;
  logic                 ack_load, word_switch, data_bit;
  logic [addr_bits-1:0] shift_in;
  logic [7:0]           cur_byte;
  logic [4:0]           id_idx;

  // Pin synchronisers plus one edge-detect flop each for SCK and SS.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sck_s1_q   <= 1'b0;
      sck_s2_q   <= 1'b0;
      sck_prev_q <= 1'b0;
      ss_s1_q    <= 1'b1;
      ss_s2_q    <= 1'b1;
      ss_prev_q  <= 1'b1;
      mosi_s1_q  <= 1'b0;
      mosi_s2_q  <= 1'b0;
    end else begin
      sck_s1_q   <= spi_sck;
      sck_s2_q   <= sck_s1_q;
      sck_prev_q <= sck_s2_q;
      ss_s1_q    <= spi_ss;
      ss_s2_q    <= ss_s1_q;
      ss_prev_q  <= ss_s2_q;
      mosi_s1_q  <= spi_mosi;
      mosi_s2_q  <= mosi_s1_q;
    end
  end

  assign sck_rise = sck_s2_q & ~sck_prev_q;
  assign sck_fall = ~sck_s2_q & sck_prev_q;
  assign ss_fall  = ~ss_s2_q & ss_prev_q;
  assign shift_in = {shift_q, mosi_s2_q};
  assign cur_byte = cur_word_q[{byte_ptr_q, 3'b000} +: 8];
  assign data_bit = cur_byte[~bit_cnt_q[2:0]];
  assign id_idx   = 5'd31 - bit_cnt_q[4:0];
  // Data returning after SS went high belongs to an aborted frame.
  assign ack_load = mem_ack & mem_req_q & ~ss_s2_q & (state_q == S_READ);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_ptr_d  = byte_ptr_q;
    miso_d      = miso_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    nxt_waddr_d = nxt_waddr_q;
    cur_vld_d   = cur_vld_q;
    pf_vld_d    = pf_vld_q;
    pf_pend_d   = pf_pend_q;
    underrun_d  = underrun_q;
    shift_d     = shift_q;
    cur_word_d  = cur_word_q;
    pf_word_d   = pf_word_q;
    word_switch = 1'b0;

    if (mem_ack && mem_req_q) begin
      mem_req_d = 1'b0;
    end

    // Deferred prefetch: waits for any request still in flight.
    if (!ss_s2_q && state_q == S_READ && pf_pend_q && !mem_req_q) begin
      mem_req_d   = 1'b1;
      mem_addr_d  = nxt_waddr_q;
      nxt_waddr_d = nxt_waddr_q + WA_W'(1);
      pf_pend_d   = 1'b0;
    end

    if (ss_s2_q) begin
      // SS high overrides any SCK edge seen in the same cycle.
      state_d   = S_IDLE;
      miso_d    = 1'b1;
      bit_cnt_d = 6'd0;
      cur_vld_d = 1'b0;
      pf_vld_d  = 1'b0;
      pf_pend_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ss_fall) begin
            state_d   = S_CMD;
            bit_cnt_d = 6'd0;
          end
        end
        S_CMD: begin
          if (sck_rise) begin
            shift_d   = shift_in[addr_bits-2:0];
            bit_cnt_d = bit_cnt_q + 6'd1;
            if (bit_cnt_q == 6'd7) begin
              bit_cnt_d = 6'd0;
              case (shift_in[7:0])
                8'h03:   state_d = S_ADDR;
                8'h9F:   state_d = S_ID;
                default: state_d = S_IGNORE;
              endcase
            end
          end
        end
        S_ADDR: begin
          if (sck_rise) begin
            shift_d   = shift_in[addr_bits-2:0];
            bit_cnt_d = bit_cnt_q + 6'd1;
            if (bit_cnt_q == ADDR_LAST) begin
              state_d     = S_READ;
              bit_cnt_d   = 6'd0;
              mem_req_d   = 1'b1;
              mem_addr_d  = shift_in[addr_bits-1:2];
              nxt_waddr_d = shift_in[addr_bits-1:2] + WA_W'(1);
              byte_ptr_d  = shift_in[1:0];
              cur_vld_d   = 1'b0;
              pf_vld_d    = 1'b0;
              pf_pend_d   = 1'b0;
            end
          end
        end
        S_READ: begin
          if (sck_fall) begin
            if (cur_vld_q) begin
              miso_d = data_bit;
            end else begin
              miso_d     = 1'b0;
              underrun_d = 1'b1;
            end
            // Last byte of the word starts: ask for the next word.
            if (bit_cnt_q[2:0] == 3'd0 && byte_ptr_q == 2'd3) begin
              pf_pend_d = 1'b1;
            end
            bit_cnt_d = {3'b000, bit_cnt_q[2:0] + 3'd1};
            if (bit_cnt_q[2:0] == 3'd7) begin
              byte_ptr_d = byte_ptr_q + 2'd1;
              if (byte_ptr_q == 2'd3) begin
                word_switch = 1'b1;
              end
            end
          end
        end
        S_ID: begin
          if (sck_fall) begin
            if (bit_cnt_q < 6'd24) begin
              miso_d    = ID_EXT[id_idx];
              bit_cnt_d = bit_cnt_q + 6'd1;
            end else begin
              miso_d = 1'b1;
            end
          end
        end
        S_IGNORE: begin
          miso_d = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
          miso_d  = 1'b1;
        end
      endcase
    end

    // Word buffers. On a switch the prefetch register moves into the
    // current slot; a same-cycle ack fills whichever slot is now empty.
    if (word_switch) begin
      cur_word_d = pf_word_q;
      cur_vld_d  = pf_vld_q;
      pf_vld_d   = 1'b0;
      if (ack_load) begin
        if (pf_vld_q) begin
          pf_word_d = mem_rdata;
          pf_vld_d  = 1'b1;
        end else begin
          cur_word_d = mem_rdata;
          cur_vld_d  = 1'b1;
        end
      end
    end else if (ack_load) begin
      if (!cur_vld_q) begin
        cur_word_d = mem_rdata;
        cur_vld_d  = 1'b1;
      end else begin
        pf_word_d = mem_rdata;
        pf_vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= 6'd0;
      byte_ptr_q  <= 2'd0;
      miso_q      <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      nxt_waddr_q <= '0;
      cur_vld_q   <= 1'b0;
      pf_vld_q    <= 1'b0;
      pf_pend_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_ptr_q  <= byte_ptr_d;
      miso_q      <= miso_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      nxt_waddr_q <= nxt_waddr_d;
      cur_vld_q   <= cur_vld_d;
      pf_vld_q    <= pf_vld_d;
      pf_pend_q   <= pf_pend_d;
      underrun_q  <= underrun_d;
    end
  end

  // Datapath registers carry no reset; their valid bits qualify them.
  always_ff @(posedge clock) begin
    shift_q    <= shift_d;
    cur_word_q <= cur_word_d;
    pf_word_q  <= pf_word_d;
  end

  assign spi_miso = miso_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign busy     = ~ss_s2_q;
  assign underrun = underrun_q;

endmodule
